// File: rtl/error_injection_sequencer.sv
// Error-injection sequencer: queues {code, delay, width} commands in a small FIFO and
// plays each one out as a delayed, fixed-length err_en/err_ctrl pulse to the routers.
module error_injection_sequencer #(
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CTRL_W-1:0] cmd_code,
  input  logic [15:0]       cmd_delay,
  input  logic [15:0]       cmd_width,
  input  logic              arm,
  input  logic              abort,
  output logic              err_en,
  output logic [CTRL_W-1:0] err_ctrl,
  output logic              busy,
  output logic [15:0]       inj_count
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = CTRL_W + 32;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_INJECT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        width_q, width_d;
  logic [CTRL_W-1:0]  code_q, code_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   mem_d [DEPTH];
  logic               err_en_q, err_en_d;
  logic [CTRL_W-1:0]  err_ctrl_q, err_ctrl_d;
  logic               busy_q, busy_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic [15:0]        inj_count_q, inj_count_d;

  logic               push_s, pop_s, done_s;
  logic [CTRL_W-1:0]  head_code_s;
  logic [15:0]        head_delay_s, head_width_s;

  // cmd_ready is a flop of occupancy, so a same-cycle pop never frees a full FIFO
  assign push_s       = cmd_valid && cmd_ready_q && !abort;
  assign pop_s        = (state_q == S_IDLE) && arm && (count_q != '0) && !abort;
  assign head_code_s  = mem_q[rd_ptr_q][ENT_W-1:32];
  assign head_delay_s = mem_q[rd_ptr_q][31:16];
  assign head_width_s = mem_q[rd_ptr_q][15:0];

  // Next-state logic for the FIFO and the sequencing FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    code_d   = code_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    done_s   = 1'b0;
    if (abort) begin
      state_d  = S_IDLE;
      cnt_d    = 16'd0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = {cmd_code, cmd_delay, cmd_width};
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            code_d  = head_code_s;
            width_d = (head_width_s == 16'd0) ? 16'd1 : head_width_s;
            if (head_delay_s != 16'd0) begin
              state_d = S_DELAY;
              cnt_d   = head_delay_s;
            end else begin
              state_d = S_INJECT;
              cnt_d   = (head_width_s == 16'd0) ? 16'd1 : head_width_s;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DELAY: begin
          if (cnt_q <= 16'd1) begin
            state_d = S_INJECT;
            cnt_d   = width_q;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_INJECT: begin
          if (cnt_q <= 16'd1) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
            done_s  = 1'b1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  // Registered outputs are computed from the next state so they align with state_q
  always_comb begin
    err_en_d    = (state_d == S_INJECT);
    err_ctrl_d  = (state_d == S_INJECT) ? code_d : '0;
    busy_d      = (state_d != S_IDLE) || (count_d != '0);
    cmd_ready_d = (count_d != CNT_FULL);
    if (done_s && (inj_count_q != 16'hFFFF)) begin
      inj_count_d = inj_count_q + 16'd1;
    end else begin
      inj_count_d = inj_count_q;
    end
  end

  // State registers with asynchronous clear so reset drops err_en immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      width_q     <= 16'd0;
      code_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      err_en_q    <= 1'b0;
      err_ctrl_q  <= '0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      inj_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      code_q      <= code_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
      err_en_q    <= err_en_d;
      err_ctrl_q  <= err_ctrl_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      inj_count_q <= inj_count_d;
    end
  end

  assign err_en    = err_en_q;
  assign err_ctrl  = err_ctrl_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;
  assign inj_count = inj_count_q;

endmodule

// File: tb/tb_error_injection_sequencer.sv
// Scoreboard bench for error_injection_sequencer: each accepted command queues an
// expected pulse (code, length, optional start cycle) that the pulse monitor checks.
module tb_error_injection_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, arm, abort, err_en, busy;
  logic [15:0] cmd_code, cmd_delay, cmd_width, err_ctrl, inj_count;

  typedef struct {
    logic [15:0] code;
    int          len;
    int          start;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   run_len = 0;
  int   run_start = 0;
  logic [15:0] run_code = 16'd0;

  logic [15:0] q_delay [4] = '{16'd0, 16'd1, 16'd0, 16'd2};
  logic [15:0] q_width [4] = '{16'd1, 16'd2, 16'd3, 16'd0};

  error_injection_sequencer #(.CTRL_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_delay(cmd_delay), .cmd_width(cmd_width),
    .arm(arm), .abort(abort), .err_en(err_en), .err_ctrl(err_ctrl),
    .busy(busy), .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: measures each err_en run and compares it with the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run_len = 0;
    end else if (err_en) begin
      if (run_len == 0) begin
        run_start = cyc;
        run_code  = err_ctrl;
      end
      run_len++;
    end else if (run_len > 0) begin
      check("pulse_expected", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("pulse_code", run_code, e.code);
        check("pulse_len", run_len, e.len);
        if (e.start >= 0) check("pulse_start", run_start, e.start);
      end
      check("ctrl_zero_after", err_ctrl, 16'd0);
      run_len = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] code, input logic [15:0] d, input logic [15:0] w,
                      input bit track);
    int   n = 0;
    exp_t e;
    while (!cmd_ready && n < 200) begin
      step(1);
      n++;
    end
    check("ready_before_send", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_delay = d;
    cmd_width = w;
    step(1);
    cmd_valid = 1'b0;
    e.code  = code;
    e.len   = (w == 16'd0) ? 1 : int'(w);
    e.start = track ? (cyc + int'(d) + 1) : -1;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || err_en) && n < 500) begin
      step(1);
      n++;
    end
    check({tag, "_idle_timeout"}, n < 500, 1'b1);
    step(2);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int s;
    int saved;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = 16'd0; cmd_delay = 16'd0;
    cmd_width = 16'd0; arm = 1'b1; abort = 1'b0;
    step(3);
    check("rst_err_en", err_en, 1'b0);
    check("rst_err_ctrl", err_ctrl, 16'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_inj_count", inj_count, 16'd0);

    // Accept right on the first edge after release, zero delay
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    send(16'd5, 16'd0, 16'd3, 1'b1);
    wait_idle("single");
    check("single_count", inj_count, 16'd1);

    send(16'd9, 16'd4, 16'd2, 1'b1);
    wait_idle("delay4");
    check("delay4_count", inj_count, 16'd2);

    send(16'd7, 16'd0, 16'd0, 1'b1);
    wait_idle("width0");
    check("width0_count", inj_count, 16'd3);

    // Fill the FIFO while disarmed, then try one push too many
    arm = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h11 + 16'(i), q_delay[i], q_width[i], 1'b0);
    check("full_ready_low", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    cmd_valid = 1'b1; cmd_code = 16'h99; cmd_delay = 16'd0; cmd_width = 16'd1;
    step(1);
    cmd_valid = 1'b0;
    check("full_still_low", cmd_ready, 1'b0);
    step(3);
    check("disarmed_no_pulse", err_en, 1'b0);
    arm = 1'b1;
    wait_idle("fifo_drain");
    check("fifo_drain_count", inj_count, 16'd7);

    // Disarm right after the first pop: current command finishes, second stays queued
    send(16'h21, 16'd3, 16'd2, 1'b1);
    send(16'h22, 16'd0, 16'd1, 1'b0);
    arm = 1'b0;
    step(20);
    check("disarm_count", inj_count, 16'd8);
    check("disarm_busy", busy, 1'b1);
    arm = 1'b1;
    wait_idle("rearm");
    check("rearm_count", inj_count, 16'd9);

    // Abort in the second cycle of a long injection with two commands queued
    send(16'h31, 16'd0, 16'd10, 1'b1);
    s = sb_q[0].start;
    send(16'h32, 16'd0, 16'd1, 1'b0);
    send(16'h33, 16'd0, 16'd1, 1'b0);
    while (cyc < s + 1) step(1);
    check("abort_pre_en", err_en, 1'b1);
    saved = int'(inj_count);
    abort = 1'b1;
    sb_q[0].len = 2;
    while (sb_q.size() > 1) void'(sb_q.pop_back());
    step(1);
    abort = 1'b0;
    check("abort_err_en", err_en, 1'b0);
    check("abort_err_ctrl", err_ctrl, 16'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    check("abort_count", inj_count, 16'(saved));
    step(15);
    check("abort_no_restart", err_en, 1'b0);
    check("abort_sb_empty", sb_q.size(), 0);

    // Asynchronous reset in the middle of an injection, between clock edges
    send(16'h41, 16'd0, 16'd8, 1'b1);
    s = sb_q[0].start;
    while (cyc < s + 2) step(1);
    check("rstmid_pre_en", err_en, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("rstmid_err_en", err_en, 1'b0);
    check("rstmid_err_ctrl", err_ctrl, 16'd0);
    check("rstmid_ready", cmd_ready, 1'b1);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_count", inj_count, 16'd0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    send(16'h42, 16'd2, 16'd2, 1'b1);
    wait_idle("post_rst");
    check("post_rst_count", inj_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/error_injection_sequencer.md
ERROR_INJECTION_SEQUENCER -- requirements
Module: error_injection_sequencer

Interface
REQ-001 The block SHALL expose the following parameters:
- CTRL_W, default 16, width of the err_ctrl code driven to the downstream control routers.
- DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 The block SHALL expose the following ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command presented.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_code  in  CTRL_W  error code to drive on err_ctrl.
- cmd_delay  in  16  idle cycles before injection.
- cmd_width  in  16  injection length in cycles.
- arm  in  1  level; permits popping new commands.
- abort  in  1  synchronous kill and flush.
- err_en  out  1  injection enable to the routers.
- err_ctrl  out  CTRL_W  injection code to the routers.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- inj_count  out  16  completed injections, saturating.

Function
REQ-003 Command accept SHALL occur on any rising edge with cmd_valid=1 and cmd_ready=1, writing {code, delay, width} into the FIFO tail.
REQ-004 cmd_ready SHALL be derived from registered FIFO occupancy only, and SHALL NOT depend on a same-cycle pop.
- When the FIFO is full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-005 The FSM SHALL have exactly three states: IDLE, DELAY and INJECT.
REQ-006 IDLE SHALL behave as follows:
- If arm=1 and the FIFO is non-empty, the block SHALL pop the head and latch code/delay/width.
- Next state SHALL be DELAY with counter=delay if delay!=0, else INJECT.
REQ-007 DELAY SHALL decrement its counter each cycle and SHALL move to INJECT on the edge where counter==1, so that DELAY lasts exactly D cycles.
REQ-008 INJECT SHALL last W cycles and return to IDLE; W=0 SHALL be treated as W=1.
REQ-009 err_en SHALL be 1 only in INJECT.
- err_ctrl SHALL equal the latched code in INJECT and SHALL be all-zero otherwise.
- Both outputs SHALL be registered, glitch-free functions of state.
REQ-010 Timing SHALL be as follows: with the FSM in IDLE, FIFO empty and arm=1, a command accepted on edge t SHALL occupy DELAY for the cycles after edges t+1..t+D and INJECT after edges t+D+1..t+D+W.
REQ-011 Between consecutive injections the FSM SHALL spend at least one IDLE cycle with err_en=0, even when back-to-back commands have delay 0.
REQ-012 arm deasserted mid-command SHALL NOT affect the current command, which SHALL complete; no further pop SHALL occur while arm=0.
REQ-013 abort=1 on an edge SHALL take priority over all else:
- FSM SHALL go to IDLE.
- FIFO SHALL be flushed to empty.
- err_en/err_ctrl SHALL be 0 from the next cycle.
- A simultaneous push SHALL be discarded.
- An aborted injection SHALL NOT count.
REQ-014 inj_count SHALL increment on each INJECT->IDLE transition not caused by abort, and SHALL saturate at 16'hFFFF.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.

Reset
REQ-016 While rst_n=0 the block SHALL be asynchronously forced to its reset state:
- FSM SHALL be IDLE.
- FIFO SHALL be empty.
- err_en=0, err_ctrl=0, inj_count=0, busy=0, cmd_ready=1.
REQ-017 Reset asserted mid-injection SHALL drop err_en within the same cycle, without waiting for a clock edge.
REQ-018 Release of reset SHALL be assumed synchronous to clk; the first accept is possible on the first edge after release.

Verification
REQ-019 Single command code=5, delay=0, width=3, arm=1 -> err_en high exactly 3 cycles with err_ctrl=5, starting the cycle after edge t+1; inj_count=1.
REQ-020 code=9, delay=4, width=2 -> 4 cycles of err_en=0 after pop, then 2 cycles err_en=1 with err_ctrl=9; err_ctrl=0 before and after.
REQ-021 arm=0, push DEPTH+1 commands -> cmd_ready drops after DEPTH accepts and the extra one is refused; arm=1 -> DEPTH injections in order, each separated by at least 1 IDLE cycle, and inj_count=DEPTH.
REQ-022 abort in the 2nd cycle of a width=10 injection with 2 commands queued -> err_en=0 next cycle, FIFO empty, busy=0, inj_count unchanged.
REQ-023 Command with width=0 -> exactly 1 cycle of err_en=1.
REQ-024 rst_n pulled low mid-INJECT between clock edges -> err_en and err_ctrl 0 immediately, cmd_ready=1, and all state cleared.
